// File: rtl/trng_sample_ctrl.sv
// trng_sample_ctrl: ring-oscillator sequencing, sampling, debiasing, health test and byte assembly
module trng_sample_ctrl #(
    parameter int DIV_W         = 8,
    parameter int WARMUP_CYCLES = 64,
    parameter int RCT_LIMIT     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_vn_en,
    input  logic             raw_bit,
    input  logic             clr_err,
    output logic             osc_en,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             health_fail
);
    localparam int WW = $clog2(WARMUP_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, WARMUP, COLLECT, HOLD, FAIL} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d, cdiv_q, cdiv_d;
    logic [WW-1:0]    wcnt_q, wcnt_d;
    logic [7:0]       rct_q, rct_d, rct_n;
    logic [7:0]       shreg_q, shreg_d, data_q, data_d;
    logic [2:0]       nbits_q, nbits_d;
    logic             vn_q, vn_d, last_q, last_d, phase_q, phase_d, b0_q, b0_d, valid_q, valid_d;
    logic             tick, acc, abit, trip;

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            cdiv_q  <= '0;
            wcnt_q  <= '0;
            rct_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            nbits_q <= '0;
            vn_q    <= 1'b0;
            last_q  <= 1'b0;
            phase_q <= 1'b0;
            b0_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cdiv_q  <= cdiv_d;
            wcnt_q  <= wcnt_d;
            rct_q   <= rct_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            nbits_q <= nbits_d;
            vn_q    <= vn_d;
            last_q  <= last_d;
            phase_q <= phase_d;
            b0_q    <= b0_d;
            valid_q <= valid_d;
        end
    end

    // next-state: sequencing, sample tick, repetition count, debiasing and assembly
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cdiv_d  = cdiv_q;
        wcnt_d  = wcnt_q;
        rct_d   = rct_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        nbits_d = nbits_q;
        vn_d    = vn_q;
        last_d  = last_q;
        phase_d = phase_q;
        b0_d    = b0_q;
        valid_d = valid_q;
        tick    = 1'b0;
        acc     = 1'b0;
        abit    = 1'b0;
        trip    = 1'b0;
        rct_n   = rct_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    cdiv_d  = cfg_div;
                    vn_d    = cfg_vn_en;
                    wcnt_d  = '0;
                    state_d = WARMUP;
                end
            end
            WARMUP: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (wcnt_q == WW'(WARMUP_CYCLES - 1)) begin
                    state_d = COLLECT;
                    div_d   = '0;
                    rct_d   = '0;
                    phase_d = 1'b0;
                    nbits_d = '0;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            COLLECT: begin
                tick  = div_q == cdiv_q;
                div_d = tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    rct_n   = (rct_q != 8'd0 && raw_bit == last_q) ? rct_q + 8'd1 : 8'd1;
                    rct_d   = rct_n;
                    last_d  = raw_bit;
                    trip    = rct_n == 8'(RCT_LIMIT);
                    phase_d = vn_q ? !phase_q : phase_q;
                    b0_d    = (vn_q && !phase_q) ? raw_bit : b0_q;
                    acc     = vn_q ? (phase_q && raw_bit != b0_q) : 1'b1;
                    abit    = vn_q ? b0_q : raw_bit;
                end
                if (trip) begin
                    state_d = FAIL;
                end else if (!en) begin
                    state_d = IDLE;
                end else if (acc) begin
                    shreg_d = {shreg_q[6:0], abit};
                    nbits_d = nbits_q + 1'b1;
                    if (nbits_q == 3'd7) begin
                        data_d  = {shreg_q[6:0], abit};
                        valid_d = 1'b1;
                        phase_d = 1'b0;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    phase_d = 1'b0;
                    state_d = en ? COLLECT : IDLE;
                end else if (!en) begin
                    state_d = IDLE;
                end
            end
            FAIL: begin
                valid_d = 1'b0;
                state_d = clr_err ? IDLE : FAIL;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE && state_q != IDLE) begin
            valid_d = 1'b0;
            nbits_d = '0;
            shreg_d = '0;
        end
    end

    assign osc_en      = state_q == WARMUP || state_q == COLLECT || state_q == HOLD;
    assign busy        = state_q != IDLE;
    assign health_fail = state_q == FAIL;
    assign out_data    = data_q;
    assign out_valid   = valid_q;
endmodule

// File: tb/tb_trng_sample_ctrl.sv
// tb_trng_sample_ctrl: directed stimulus with a byte scoreboard checked by an independent monitor
module tb_trng_sample_ctrl;
    logic       clk = 1'b0;
    logic       rst, en, cfg_vn_en, raw_bit, clr_err, out_ready;
    logic [7:0] cfg_div;
    logic       osc_en, out_valid, busy, health_fail;
    logic [7:0] out_data;
    int         tests = 0;
    int         fails = 0;
    int         vcnt = 0;
    logic [7:0] exp_q[$];

    trng_sample_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .cfg_div(cfg_div), .cfg_vn_en(cfg_vn_en),
        .raw_bit(raw_bit), .clr_err(clr_err), .osc_en(osc_en), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: one step after each falling edge, once the bench has driven its inputs
    always begin
        @(negedge clk);
        #1;
        if (out_valid) vcnt++;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_byte: got %0h expected none at %0t", out_data, $time);
            end else begin
                chk("byte", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic start(input logic [7:0] d, input logic vn, input string tag);
        cfg_div   = d;
        cfg_vn_en = vn;
        en        = 1'b1;
        chk({tag, "_osc_before"}, {31'd0, osc_en}, 32'd0);
        @(negedge clk);
        chk({tag, "_osc_after"}, {31'd0, osc_en}, 32'd1);
        repeat (64) @(negedge clk);
    endtask

    task automatic feed(input logic [31:0] bits, input int n, input int d);
        for (int i = n - 1; i >= 0; i--) begin
            raw_bit = bits[i];
            repeat (d + 1) @(negedge clk);
        end
    endtask

    task automatic stop();
        repeat (3) @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cfg_div = '0; cfg_vn_en = 1'b0;
        raw_bit = 1'b0; clr_err = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_osc_en", {31'd0, osc_en}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_health_fail", {31'd0, health_fail}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        // first tick exactly 64 cycles into warm-up, one sample per cycle
        exp_q.push_back(8'hA5);
        start(8'd0, 1'b0, "t1");
        chk("t1_busy", {31'd0, busy}, 32'd1);
        feed(32'hA5, 8, 0);
        stop();
        chk("t1_idle_busy", {31'd0, busy}, 32'd0);
        // divider 3, single-cycle valid
        vcnt = 0;
        exp_q.push_back(8'hB2);
        start(8'd3, 1'b0, "t2");
        feed(32'hB2, 8, 3);
        stop();
        chk("t2_valid_cycles", vcnt, 32'd1);
        // von Neumann pairs 01,11,10,00,10,01,01,10,10,01
        exp_q.push_back(8'h66);
        start(8'd0, 1'b1, "t3");
        feed(32'h78969, 20, 0);
        stop();
        // back-pressure stall then resume
        out_ready = 1'b0;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h5A);
        start(8'd1, 1'b0, "t4");
        feed(32'h3C, 8, 1);
        for (int i = 0; i < 20; i++) begin
            raw_bit = i[0];
            chk("t4_stall_valid", {31'd0, out_valid}, 32'd1);
            chk("t4_stall_data", {24'd0, out_data}, 32'h3C);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        feed(32'h5A, 8, 1);
        stop();
        chk("t4_drained", exp_q.size(), 32'd0);
        // repetition-count failure with raw held at 1 (debiased, so no bytes)
        start(8'd0, 1'b1, "t5");
        raw_bit = 1'b1;
        repeat (31) @(negedge clk);
        chk("t5_no_fail_31", {31'd0, health_fail}, 32'd0);
        @(negedge clk);
        chk("t5_fail_32", {31'd0, health_fail}, 32'd1);
        chk("t5_osc_off", {31'd0, osc_en}, 32'd0);
        chk("t5_no_valid", {31'd0, out_valid}, 32'd0);
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_sticky", {31'd0, health_fail}, 32'd1);
        chk("t5_sticky_osc", {31'd0, osc_en}, 32'd0);
        en = 1'b0;
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("t5_cleared", {31'd0, health_fail}, 32'd0);
        chk("t5_idle", {31'd0, busy}, 32'd0);
        raw_bit = 1'b0;
        // abort after 5 accepted bits, restart discards the partial byte
        start(8'd0, 1'b0, "t6");
        feed(32'h1F, 5, 0);
        en = 1'b0;
        @(negedge clk);
        chk("t6_abort_idle", {31'd0, busy}, 32'd0);
        chk("t6_data_kept", {24'd0, out_data}, 32'h5A);
        repeat (2) @(negedge clk);
        exp_q.push_back(8'h0F);
        start(8'd0, 1'b0, "t6r");
        feed(32'h0F, 8, 0);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        chk("final_drained", exp_q.size(), 32'd0);
        stop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
